// File: rtl/clint_pkg.sv
// Shared CLINT definitions: register offsets within the 64 KiB region,
// reset constants and the byte-lane merge used by every writable register.
package clint_pkg;

   localparam logic [15:0] OFF_MSIP     = 16'h0000;
   localparam logic [15:0] OFF_MTIMECMP = 16'h4000;
   localparam logic [15:0] OFF_MTIME    = 16'hBFF8;

   localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

   function automatic logic [63:0] byte_merge(input logic [63:0] old_val,
                                              input logic [63:0] new_val,
                                              input logic [7:0]  strb);
      logic [63:0] res;
      res = old_val;
      for (int i = 0; i < 8; i++) begin
         if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/clint_prescaler.sv
// mtime prescaler: counts 0..PRESCALE-1 and pulses o_tick in the wrap cycle.
module clint_prescaler #(
   parameter int unsigned PRESCALE = 1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   output logic o_tick
);

   localparam logic [15:0] LAST = 16'(PRESCALE - 1);

   logic [15:0] r_count;
   logic        w_tick;

   assign w_tick = (r_count == LAST);
   assign o_tick = w_tick;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)    r_count <= '0;
      else if (w_tick) r_count <= '0;
      else             r_count <= r_count + 16'd1;
   end

endmodule

// File: rtl/clint.sv
// Core-local interruptor: msip, mtimecmp and a prescaled 64-bit mtime with
// combinational reads, byte-strobed writes and registered interrupt outputs.
module clint
   import clint_pkg::*;
#(
   parameter logic [63:0] BASE     = 64'h0000_0000_0200_0000,
   parameter int unsigned PRESCALE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clint_re,
   input  logic        clint_we,
   input  logic [63:0] clint_addr,
   input  logic [63:0] clint_wdata,
   input  logic [7:0]  clint_wstrb,
   output logic [63:0] clint_dout,
   output logic        clint_mtip,
   output logic        clint_msip
);

   logic [63:0] r_mtime;
   logic [63:0] r_mtimecmp;
   logic        r_msip;
   logic        r_mtip;

   logic        w_tick;
   logic        w_in_region;
   logic [15:0] w_off;
   logic        w_sel_msip;
   logic        w_sel_cmp;
   logic        w_sel_mtime;
   logic [63:0] w_mtime_inc;
   logic [63:0] w_mtime_nxt;
   logic [63:0] w_mtimecmp_nxt;
   logic        w_msip_nxt;

   clint_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
      .i_clk   (clk),
      .i_rst_n (rst),
      .o_tick  (w_tick)
   );

   // Low address bits are dropped so any byte address inside a word hits it.
   assign w_in_region = (clint_addr[63:16] == BASE[63:16]);
   assign w_off       = clint_addr[15:0] & 16'hFFF8;
   assign w_sel_msip  = w_in_region && (w_off == OFF_MSIP);
   assign w_sel_cmp   = w_in_region && (w_off == OFF_MTIMECMP);
   assign w_sel_mtime = w_in_region && (w_off == OFF_MTIME);

   always_comb begin
      clint_dout = '0;
      if (clint_re) begin
         if (w_sel_msip)       clint_dout = {63'd0, r_msip};
         else if (w_sel_cmp)   clint_dout = r_mtimecmp;
         else if (w_sel_mtime) clint_dout = r_mtime;
      end
   end

   // A write in a tick cycle merges onto the incremented value.
   assign w_mtime_inc = w_tick ? r_mtime + 64'd1 : r_mtime;
   assign w_mtime_nxt = (clint_we && w_sel_mtime)
                        ? byte_merge(w_mtime_inc, clint_wdata, clint_wstrb)
                        : w_mtime_inc;
   assign w_mtimecmp_nxt = (clint_we && w_sel_cmp)
                           ? byte_merge(r_mtimecmp, clint_wdata, clint_wstrb)
                           : r_mtimecmp;
   assign w_msip_nxt = (clint_we && w_sel_msip && clint_wstrb[0])
                       ? clint_wdata[0] : r_msip;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mtime    <= '0;
         r_mtimecmp <= MTIMECMP_RST;
         r_msip     <= 1'b0;
         r_mtip     <= 1'b0;
      end else begin
         r_mtime    <= w_mtime_nxt;
         r_mtimecmp <= w_mtimecmp_nxt;
         r_msip     <= w_msip_nxt;
         r_mtip     <= (r_mtime >= r_mtimecmp);
      end
   end

   assign clint_mtip = r_mtip;
   assign clint_msip = r_msip;

endmodule

// File: doc/clint.md
CLINT -- requirements
Module: clint

Interface
REQ-001 SHALL have parameter BASE, default 64'h0000_0000_0200_0000: base byte address of the 64 KiB CLINT region.
REQ-002 SHALL have parameter PRESCALE, default 1, legal range 1..65535: clk cycles per mtime increment.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous assert, active-low (0 = in reset).
REQ-005 SHALL have port clint_re  in  1  read strobe from LSU.
REQ-006 SHALL have port clint_we  in  1  write strobe from LSU.
REQ-007 SHALL have port clint_addr  in  64  byte address; addr[2:0] ignored, 8-byte aligned access.
REQ-008 SHALL have port clint_wdata  in  64  write data.
REQ-009 SHALL have port clint_wstrb  in  8  byte enables for writes; bit i enables byte i.
REQ-010 SHALL have port clint_dout  out  64  read data.
REQ-011 SHALL have port clint_mtip  out  1  machine timer interrupt pending, registered.
REQ-012 SHALL have port clint_msip  out  1  machine software interrupt pending, registered.

Function
REQ-013 Register map SHALL be: msip at BASE+0x0000 (bit0 only, others read 0); mtimecmp at BASE+0x4000; mtime at BASE+0xBFF8, all 64-bit.
REQ-014 Addresses outside the map, or inside the region but unmapped, SHALL read 64'h0 and ignore writes.
REQ-015 Reads SHALL be combinational, zero latency: clint_dout = selected register when clint_re=1 and addr maps, else 64'h0.
REQ-016 Writes SHALL take effect at the next rising edge, merged bytewise under clint_wstrb; unstrobed bytes keep their value.
REQ-017 clint_re and clint_we together SHALL return the pre-write value on clint_dout; the write still commits.
REQ-018 Prescaler SHALL count 0..PRESCALE-1 and wrap to 0; mtime SHALL increment by 1 in the cycle of that wrap (tick).
REQ-019 mtime SHALL wrap modulo 2^64 (all-ones + 1 = 0).
REQ-020 mtime write coinciding with a tick: strobed bytes SHALL take wdata, unstrobed bytes SHALL take the incremented value.
REQ-021 Writes to mtime SHALL NOT reset the prescaler.
REQ-022 clint_mtip SHALL be registered: clint_mtip <= (mtime >= mtimecmp), unsigned compare of current register values, giving 1-cycle latency.
REQ-023 clint_mtip SHALL deassert one cycle after mtimecmp is written above mtime, or after mtime wraps below mtimecmp.
REQ-024 clint_msip SHALL equal the registered msip bit0.
REQ-025 With PRESCALE=1, a tick SHALL occur every cycle.

Reset
REQ-026 While rst=0, outputs and state SHALL be forced immediately, without waiting for clk: mtime=0, prescaler=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, clint_mtip=0, clint_msip=0.
REQ-027 During reset, clint_dout SHALL follow REQ-015 from the reset register values.
REQ-028 A write or tick in progress when rst falls SHALL be discarded.
REQ-029 Counting SHALL resume at the first rising edge after rst returns to 1.

Structure
REQ-030 Shared package clint_pkg SHALL hold the register offsets (0x0000, 0x4000, 0xBFF8), the mtimecmp reset constant and a byte-merge function (old, new, strobe).
REQ-031 The prescaler SHALL be a single sub-module clint_prescaler (count, tick out); everything else SHALL be flat in clint.

Verification
REQ-032 Release reset with PRESCALE=1 and wait 10 cycles -> mtime read returns 10, clint_mtip=0.
REQ-033 Write mtimecmp=20 with wstrb=8'hFF -> clint_mtip=1 first in the cycle after mtime reads 20.
REQ-034 Write mtimecmp with wstrb=8'h0F, wdata=64'h1234_5678 from reset -> mtimecmp reads 64'hFFFF_FFFF_1234_5678.
REQ-035 Write mtime=64'hFFFF_FFFF_FFFF_FFFF with mtimecmp=5 -> mtip=1; after the next tick mtime reads 0, and mtip=0 one cycle later.
REQ-036 Write mtime=100 with wstrb=8'hFF on a tick cycle -> reads 100, then 101 on the next cycle.
REQ-037 Drive rst=0 mid-count between clock edges -> mtime=0 and clint_mtip=0 immediately; msip write 1 then read -> clint_msip=1, dout=64'h1.
